// File: rtl/axis_sync_merge.sv
// axis_sync_merge
// Two-input, frame-atomic AXI-Stream merger for the sync Ethernet TX path.
// Host frames and RX-forward frames are interleaved at frame granularity
// using round-robin arbitration. A grant is held from the first beat to tlast.
// The merged stream leaves through a register + temp skid stage.
//
// State table:
//   state     | meaning
//   ST_IDLE   | no grant held; arbitrate between ports with tvalid
//   ST_ACTIVE | grant_reg port owns the output until its tlast is accepted
//
// Ports:
//   clk, aresetn          clock, synchronous active-low reset
//   s_axis_host_*         host TX input stream
//   s_axis_fwd_*          forward-path input stream
//   m_axis_*              merged TX output stream toward the MAC
//   host_frame_count      frames accepted from host port (wraps)
//   fwd_frame_count       frames accepted from fwd port (wraps)
//   busy                  a grant is held
module axis_sync_merge #(
    parameter int AXIS_SYNC_DATA_WIDTH = 512,
    parameter int AXIS_SYNC_KEEP_WIDTH = AXIS_SYNC_DATA_WIDTH / 8,
    parameter int AXIS_SYNC_USER_WIDTH = 128,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                            clk,
    input  logic                            aresetn,

    input  logic [AXIS_SYNC_DATA_WIDTH-1:0] s_axis_host_tdata,
    input  logic [AXIS_SYNC_KEEP_WIDTH-1:0] s_axis_host_tkeep,
    input  logic                            s_axis_host_tvalid,
    input  logic                            s_axis_host_tlast,
    input  logic [AXIS_SYNC_USER_WIDTH-1:0] s_axis_host_tuser,
    output logic                            s_axis_host_tready,

    input  logic [AXIS_SYNC_DATA_WIDTH-1:0] s_axis_fwd_tdata,
    input  logic [AXIS_SYNC_KEEP_WIDTH-1:0] s_axis_fwd_tkeep,
    input  logic                            s_axis_fwd_tvalid,
    input  logic                            s_axis_fwd_tlast,
    input  logic [AXIS_SYNC_USER_WIDTH-1:0] s_axis_fwd_tuser,
    output logic                            s_axis_fwd_tready,

    output logic [AXIS_SYNC_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_SYNC_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [AXIS_SYNC_USER_WIDTH-1:0] m_axis_tuser,
    input  logic                            m_axis_tready,

    output logic [CNT_WIDTH-1:0]            host_frame_count,
    output logic [CNT_WIDTH-1:0]            fwd_frame_count,
    output logic                            busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic   grant_reg, grant_next;
    logic   last_grant_reg, last_grant_next;

    logic   int_ready_reg;
    logic   int_ready_early;
    logic   int_valid;

    logic                            sel_valid;
    logic                            sel_last;
    logic [AXIS_SYNC_DATA_WIDTH-1:0] sel_data;
    logic [AXIS_SYNC_KEEP_WIDTH-1:0] sel_keep;
    logic [AXIS_SYNC_USER_WIDTH-1:0] sel_user;

    logic                            m_valid_reg, m_valid_next;
    logic                            temp_valid_reg, temp_valid_next;
    logic [AXIS_SYNC_DATA_WIDTH-1:0] temp_data_reg;
    logic [AXIS_SYNC_KEEP_WIDTH-1:0] temp_keep_reg;
    logic                            temp_last_reg;
    logic [AXIS_SYNC_USER_WIDTH-1:0] temp_user_reg;
    logic                            store_int_to_out;
    logic                            store_int_to_temp;
    logic                            store_temp_to_out;

    // Input mux on the granted port
    assign sel_valid = grant_reg ? s_axis_fwd_tvalid : s_axis_host_tvalid;
    assign sel_last  = grant_reg ? s_axis_fwd_tlast  : s_axis_host_tlast;
    assign sel_data  = grant_reg ? s_axis_fwd_tdata  : s_axis_host_tdata;
    assign sel_keep  = grant_reg ? s_axis_fwd_tkeep  : s_axis_host_tkeep;
    assign sel_user  = grant_reg ? s_axis_fwd_tuser  : s_axis_host_tuser;

    // A beat is accepted only while a grant is held and the output stage has room
    assign int_valid = (state_reg == ST_ACTIVE) && sel_valid && int_ready_reg;

    assign s_axis_host_tready = (state_reg == ST_ACTIVE) && !grant_reg && int_ready_reg;
    assign s_axis_fwd_tready  = (state_reg == ST_ACTIVE) &&  grant_reg && int_ready_reg;
    assign busy               = (state_reg == ST_ACTIVE);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (s_axis_host_tvalid || s_axis_fwd_tvalid) begin
                    state_next = ST_ACTIVE;
                    // On a tie the port that did not win last time goes next
                    if (s_axis_host_tvalid && s_axis_fwd_tvalid) begin
                        grant_next = ~last_grant_reg;
                    end else begin
                        grant_next = s_axis_fwd_tvalid;
                    end
                    last_grant_next = grant_next;
                end
            end
            ST_ACTIVE: begin
                if (int_valid && sel_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            host_frame_count <= '0;
            fwd_frame_count  <= '0;
        end else if (int_valid && sel_last) begin
            if (grant_reg) begin
                fwd_frame_count <= fwd_frame_count + 1'b1;
            end else begin
                host_frame_count <= host_frame_count + 1'b1;
            end
        end
    end

    // Output skid stage. Ready is registered, so one beat may already be in
    // flight when m_axis_tready drops; the temp entry catches it.
    assign int_ready_early = m_axis_tready || (!temp_valid_reg && !m_valid_reg);

    always_comb begin
        m_valid_next      = m_valid_reg;
        temp_valid_next   = temp_valid_reg;
        store_int_to_out  = 1'b0;
        store_int_to_temp = 1'b0;
        store_temp_to_out = 1'b0;
        if (int_ready_reg) begin
            if (m_axis_tready || !m_valid_reg) begin
                m_valid_next     = int_valid;
                store_int_to_out = 1'b1;
            end else begin
                temp_valid_next   = int_valid;
                store_int_to_temp = 1'b1;
            end
        end else if (m_axis_tready) begin
            m_valid_next      = temp_valid_reg;
            temp_valid_next   = 1'b0;
            store_temp_to_out = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            m_valid_reg    <= 1'b0;
            temp_valid_reg <= 1'b0;
            int_ready_reg  <= 1'b0;
        end else begin
            m_valid_reg    <= m_valid_next;
            temp_valid_reg <= temp_valid_next;
            int_ready_reg  <= int_ready_early;
        end
    end

    // Payload registers carry no reset; valid flags qualify them
    always_ff @(posedge clk) begin
        if (store_int_to_out) begin
            m_axis_tdata <= sel_data;
            m_axis_tkeep <= sel_keep;
            m_axis_tlast <= sel_last;
            m_axis_tuser <= sel_user;
        end else if (store_temp_to_out) begin
            m_axis_tdata <= temp_data_reg;
            m_axis_tkeep <= temp_keep_reg;
            m_axis_tlast <= temp_last_reg;
            m_axis_tuser <= temp_user_reg;
        end
        if (store_int_to_temp) begin
            temp_data_reg <= sel_data;
            temp_keep_reg <= sel_keep;
            temp_last_reg <= sel_last;
            temp_user_reg <= sel_user;
        end
    end

    assign m_axis_tvalid = m_valid_reg;

endmodule

// File: tb/tb_axis_sync_merge.sv
// Testbench for axis_sync_merge: source queues drive both inputs, expected
// beats are queued in required output order and compared as they emerge.
module tb_axis_sync_merge;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [127:0] user;
        logic         last;
        int           gap;
    } beat_t;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;

    logic [511:0] s_tdata [2];
    logic [63:0]  s_tkeep [2];
    logic [127:0] s_tuser [2];
    logic         s_tvalid [2];
    logic         s_tlast [2];
    logic         host_tready, fwd_tready;

    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic [127:0] m_tuser;
    logic         m_tvalid, m_tlast;
    logic         m_tready = 1'b1;

    logic [31:0]  host_cnt, fwd_cnt;
    logic         busy;

    beat_t        src_q [2][$];
    beat_t        exp_q [$];
    int           out_cyc [$];
    bit           loaded [2];
    int           gap_cnt [2];
    bit           acc [2];

    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           in_cnt = 0;
    int           out_cnt = 0;
    bit           bp_rand = 1'b0;
    bit           host_in_frame = 1'b0;
    int           skid_viol = 0;
    int           fwd_rdy_cnt = 0;
    int           fwd_stall_viol = 0;

    axis_sync_merge dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .s_axis_host_tdata  (s_tdata[0]),
        .s_axis_host_tkeep  (s_tkeep[0]),
        .s_axis_host_tvalid (s_tvalid[0]),
        .s_axis_host_tlast  (s_tlast[0]),
        .s_axis_host_tuser  (s_tuser[0]),
        .s_axis_host_tready (host_tready),
        .s_axis_fwd_tdata   (s_tdata[1]),
        .s_axis_fwd_tkeep   (s_tkeep[1]),
        .s_axis_fwd_tvalid  (s_tvalid[1]),
        .s_axis_fwd_tlast   (s_tlast[1]),
        .s_axis_fwd_tuser   (s_tuser[1]),
        .s_axis_fwd_tready  (fwd_tready),
        .m_axis_tdata       (m_tdata),
        .m_axis_tkeep       (m_tkeep),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tlast       (m_tlast),
        .m_axis_tuser       (m_tuser),
        .m_axis_tready      (m_tready),
        .host_frame_count   (host_cnt),
        .fwd_frame_count    (fwd_cnt),
        .busy               (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_frame(input int p, input logic [511:0] base, input int n,
                              input int gap_at, input int gap_len,
                              input bit to_src, input bit to_exp);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = base + 512'(i);
            b.keep = {b.data[31:0] * 32'd3, ~b.data[31:0]};
            b.user = {b.data[63:0] ^ 64'h5a5a_5a5a_5a5a_5a5a, b.data[63:0]};
            b.last = (i == n - 1);
            b.gap  = (i == gap_at) ? gap_len : 0;
            if (to_src) src_q[p].push_back(b);
            if (to_exp) exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0
                || busy || m_tvalid) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #2;
        check(tag, 512'(n < 2000), 512'(1));
    endtask

    // Source driver: handshakes sampled mid-cycle, next beat presented after the edge
    initial begin : drv
        for (int p = 0; p < 2; p++) begin
            s_tvalid[p] = 1'b0;
            s_tlast[p]  = 1'b0;
            s_tdata[p]  = '0;
            s_tkeep[p]  = '0;
            s_tuser[p]  = '0;
            loaded[p]   = 1'b0;
            gap_cnt[p]  = 0;
        end
        forever begin
            @(negedge clk);
            acc[0] = aresetn && s_tvalid[0] && host_tready;
            acc[1] = aresetn && s_tvalid[1] && fwd_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    in_cnt++;
                    if (p == 0) host_in_frame = !s_tlast[0];
                    if (src_q[p].size() > 0) void'(src_q[p].pop_front());
                    loaded[p] = 1'b0;
                end
                if (!loaded[p] && src_q[p].size() > 0) begin
                    loaded[p]  = 1'b1;
                    gap_cnt[p] = src_q[p][0].gap;
                end
                if (loaded[p] && gap_cnt[p] > 0) begin
                    s_tvalid[p] = 1'b0;
                    gap_cnt[p]--;
                end else if (loaded[p]) begin
                    s_tvalid[p] = 1'b1;
                    s_tdata[p]  = src_q[p][0].data;
                    s_tkeep[p]  = src_q[p][0].keep;
                    s_tuser[p]  = src_q[p][0].user;
                    s_tlast[p]  = src_q[p][0].last;
                end else begin
                    s_tvalid[p] = 1'b0;
                end
            end
        end
    end

    initial begin : sink
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor and scoreboard
    initial begin : mon
        beat_t e;
        int    occ;
        forever begin
            @(negedge clk);
            occ = in_cnt - out_cnt;
            if (occ >= 2 && (host_tready || fwd_tready)) skid_viol++;
            if (fwd_tready) fwd_rdy_cnt++;
            if (host_in_frame && fwd_tready) fwd_stall_viol++;
            if (aresetn && m_tvalid && m_tready) begin
                check("exp_avail", 512'(exp_q.size() > 0), 512'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tdata", m_tdata, e.data);
                    check("tkeep", 512'(m_tkeep), 512'(e.keep));
                    check("tuser", 512'(m_tuser), 512'(e.user));
                    check("tlast", 512'(m_tlast), 512'(e.last));
                end
                out_cnt++;
                out_cyc.push_back(cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;
        int base_in;
        bit found;

        // Tie sequence loaded during reset so both ports are valid from release
        push_frame(0, 512'h100, 2, -1, 0, 1, 0);
        push_frame(0, 512'h200, 2, -1, 0, 1, 0);
        push_frame(1, 512'h8100, 2, -1, 0, 1, 0);
        push_frame(1, 512'h8200, 2, -1, 0, 1, 0);
        push_frame(0, 512'h100, 2, -1, 0, 0, 1);
        push_frame(1, 512'h8100, 2, -1, 0, 0, 1);
        push_frame(0, 512'h200, 2, -1, 0, 0, 1);
        push_frame(1, 512'h8200, 2, -1, 0, 0, 1);

        repeat (3) @(posedge clk);
        #2;
        check("rst_m_tvalid", 512'(m_tvalid), 512'(0));
        check("rst_host_tready", 512'(host_tready), 512'(0));
        check("rst_fwd_tready", 512'(fwd_tready), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_host_cnt", 512'(host_cnt), 512'(0));
        check("rst_fwd_cnt", 512'(fwd_cnt), 512'(0));
        out_cyc.delete();
        aresetn = 1'b1;
        wait_drain("tie_drain");
        check("tie_beats", 512'(out_cyc.size()), 512'(8));
        check("tie_span", 512'(out_cyc[7] - out_cyc[0]), 512'(10));
        check("tie_host_cnt", 512'(host_cnt), 512'(2));
        check("tie_fwd_cnt", 512'(fwd_cnt), 512'(2));

        // Host-only frame
        @(posedge clk);
        #2;
        out_cyc.delete();
        fwd_rdy_cnt = 0;
        k = cyc;
        push_frame(0, 512'hA1, 3, -1, 0, 1, 1);
        wait_drain("host_drain");
        check("host_latency", 512'(out_cyc[0] - (k + 1)), 512'(2));
        check("host_back2back", 512'(out_cyc[2] - out_cyc[0]), 512'(2));
        check("host_cnt_1", 512'(host_cnt), 512'(3));
        check("host_fwd_rdy", 512'(fwd_rdy_cnt), 512'(0));

        // Random backpressure on an 8-beat fwd frame
        @(posedge clk);
        #2;
        skid_viol = 0;
        bp_rand = 1'b1;
        push_frame(1, 512'h0, 8, -1, 0, 1, 1);
        wait_drain("bp_drain");
        bp_rand = 1'b0;
        check("bp_skid_full_rdy", 512'(skid_viol), 512'(0));
        check("bp_fwd_cnt", 512'(fwd_cnt), 512'(3));

        // Mid-frame gap on host while fwd waits
        @(posedge clk);
        #2;
        out_cyc.delete();
        fwd_stall_viol = 0;
        push_frame(0, 512'hB00, 3, 1, 5, 1, 1);
        push_frame(1, 512'hC00, 2, -1, 0, 1, 1);
        wait_drain("gap_drain");
        check("gap_fwd_stall", 512'(fwd_stall_viol), 512'(0));
        check("gap_bubble", 512'(out_cyc[3] - out_cyc[2]), 512'(2));
        check("gap_host_cnt", 512'(host_cnt), 512'(4));
        check("gap_fwd_cnt", 512'(fwd_cnt), 512'(4));

        // Back-to-back single-beat frames on both ports
        @(posedge clk);
        #2;
        out_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            push_frame(0, 512'h1000 + 512'(i), 1, -1, 0, 1, 0);
            push_frame(1, 512'h2000 + 512'(i), 1, -1, 0, 1, 0);
            push_frame(0, 512'h1000 + 512'(i), 1, -1, 0, 0, 1);
            push_frame(1, 512'h2000 + 512'(i), 1, -1, 0, 0, 1);
        end
        wait_drain("single_drain");
        check("single_frames", 512'(out_cyc.size()), 512'(20));
        check("single_span", 512'(out_cyc[19] - out_cyc[0]), 512'(38));
        check("single_host_cnt", 512'(host_cnt), 512'(14));
        check("single_fwd_cnt", 512'(fwd_cnt), 512'(14));

        // Reset during beat 2 of a 4-beat host frame
        @(posedge clk);
        #2;
        base_in = in_cnt;
        found = 1'b0;
        push_frame(0, 512'hE00, 4, -1, 0, 1, 1);
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            if (in_cnt == base_in + 1) found = 1'b1;
        end
        check("rst_mid_wait", 512'(found), 512'(1));
        aresetn = 1'b0;
        @(posedge clk);
        #2;
        check("rst_mid_m_tvalid", 512'(m_tvalid), 512'(0));
        check("rst_mid_host_tready", 512'(host_tready), 512'(0));
        check("rst_mid_fwd_tready", 512'(fwd_tready), 512'(0));
        check("rst_mid_busy", 512'(busy), 512'(0));
        check("rst_mid_host_cnt", 512'(host_cnt), 512'(0));
        check("rst_mid_fwd_cnt", 512'(fwd_cnt), 512'(0));
        src_q[0].delete();
        loaded[0] = 1'b0;
        s_tvalid[0] = 1'b0;
        exp_q.delete();
        in_cnt = 0;
        out_cnt = 0;
        host_in_frame = 1'b0;
        aresetn = 1'b1;

        @(posedge clk);
        #2;
        push_frame(0, 512'hF00, 2, -1, 0, 1, 1);
        wait_drain("fresh_drain");
        check("fresh_host_cnt", 512'(host_cnt), 512'(1));
        check("fresh_fwd_cnt", 512'(fwd_cnt), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
